// File: rtl/ls_multi_channel_ctrl_if.sv
// ls_multi_channel_ctrl_if
//   Bundles the core-side and DMA-side handshake/bus signals of
//   ls_multi_channel_ctrl.
//   master : controller view (drives core_ready/ack/done/readData and
//            dma_req/dma_write_*/dma_read_ready)
//   slave  : environment view (cores + DMA path controller)
//   Per-channel vectors are packed, channel i at [i*W +: W].
interface ls_multi_channel_ctrl_if #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned HADDR_W = 40,
  parameter int unsigned LADDR_W = 14,
  parameter int unsigned LEN_W   = 16
);
  logic [NUM_CH-1:0]         core_req;
  logic [NUM_CH-1:0]         core_rwn;
  logic [NUM_CH*HADDR_W-1:0] core_hostAddr;
  logic [NUM_CH*LADDR_W-1:0] core_localAddr;
  logic [NUM_CH*LEN_W-1:0]   core_transferLength;
  logic [NUM_CH*DATA_W-1:0]  core_writeData;
  logic [NUM_CH-1:0]         core_ready;
  logic [NUM_CH-1:0]         core_ack;
  logic [NUM_CH-1:0]         core_done;
  logic [DATA_W-1:0]         core_readData;

  logic                      dma_req;
  logic                      dma_resp;
  logic                      dma_write_valid;
  logic [DATA_W-1:0]         dma_write_data;
  logic                      dma_write_ready;
  logic                      dma_read_valid;
  logic [DATA_W-1:0]         dma_read_data;
  logic                      dma_read_ready;

  modport master (
    input  core_req, core_rwn, core_hostAddr, core_localAddr,
           core_transferLength, core_writeData,
    output core_ready, core_ack, core_done, core_readData,
    output dma_req,
    input  dma_resp,
    output dma_write_valid, dma_write_data,
    input  dma_write_ready, dma_read_valid, dma_read_data,
    output dma_read_ready
  );

  modport slave (
    output core_req, core_rwn, core_hostAddr, core_localAddr,
           core_transferLength, core_writeData,
    input  core_ready, core_ack, core_done, core_readData,
    input  dma_req,
    output dma_resp,
    input  dma_write_valid, dma_write_data,
    output dma_write_ready, dma_read_valid, dma_read_data,
    input  dma_read_ready
  );
endinterface

// File: rtl/ls_multi_channel_ctrl.sv
// ls_multi_channel_ctrl
//   Round-robin arbitrates NUM_CH core load/store requesters onto a single
//   DMA path-controller port. For the granted channel it issues a command
//   header beat, then streams exactly LEN write beats out or LEN read beats
//   back; acks/done go to the granted channel only.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (master) : core request/data/ack side and DMA handshake side
//   err_timeout  : (LSC_WATCHDOG_EN only) one-cycle pulse on watchdog expiry
// Optional feature:
//   `define LSC_WATCHDOG_EN adds parameter WDOG_CYC and port err_timeout;
//   a stalled transfer is forced to END after WDOG_CYC idle cycles.
module ls_multi_channel_ctrl #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned HADDR_W = 40,
  parameter int unsigned LADDR_W = 14,
  parameter int unsigned LEN_W   = 16
`ifdef LSC_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYC = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  ls_multi_channel_ctrl_if.master bus
`ifdef LSC_WATCHDOG_EN
  ,
  output logic                   err_timeout
`endif
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned HDR_W = 8 + LEN_W + HADDR_W + 2 + LADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_HDR, S_WDATA, S_RDATA, S_END
  } state_t;

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_rr, r_g;
  logic               r_rwn;
  logic [LEN_W-1:0]   r_len, r_cnt;
  logic [DATA_W-1:0]  r_hdr;

  logic               w_found;
  logic [IDX_W-1:0]   w_gidx, w_idx;
  logic [HDR_W-1:0]   w_hdr;
  logic               w_beat;
  logic               w_active;
  logic [DATA_W-1:0]  w_wdata;
`ifdef LSC_WATCHDOG_EN
  logic [31:0]        r_wdog;
  logic               w_timeout;
`endif

  // Round-robin search starting at r_rr; header built from the candidate
  // so it can be registered in the same cycle as the grant.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_idx = IDX_W'((32'(r_rr) + k) % NUM_CH);
      if (!w_found && bus.core_req[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    w_hdr = {(bus.core_rwn[w_gidx] ? 8'h01 : 8'h03),
             bus.core_transferLength[w_gidx*LEN_W +: LEN_W],
             bus.core_hostAddr[w_gidx*HADDR_W +: HADDR_W],
             2'b00,
             bus.core_localAddr[w_gidx*LADDR_W +: LADDR_W]};
  end

  assign w_wdata  = bus.core_writeData[r_g*DATA_W +: DATA_W];
  assign w_active = (r_state == S_REQ) || (r_state == S_HDR) ||
                    (r_state == S_WDATA) || (r_state == S_RDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_beat = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_REQ;
      S_REQ:   if (bus.dma_resp) w_next = S_HDR;
      S_HDR:   if (bus.dma_write_ready) begin
                 if (r_len == '0)  w_next = S_END;
                 else if (r_rwn)   w_next = S_RDATA;
                 else              w_next = S_WDATA;
               end
      S_WDATA: if (bus.dma_write_ready) begin
                 w_beat = 1'b1;
                 if (r_cnt == r_len - 1'b1) w_next = S_END;
               end
      S_RDATA: if (bus.dma_read_valid) begin
                 w_beat = 1'b1;
                 if (r_cnt == r_len - 1'b1) w_next = S_END;
               end
      S_END:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
`ifdef LSC_WATCHDOG_EN
    w_timeout = w_active && (w_next == r_state) && !w_beat &&
                (r_wdog == 32'(WDOG_CYC - 1));
    if (w_timeout) w_next = S_END;
`endif
  end

  // Outputs decode from registered state, so reset forces them all to 0.
  always_comb begin
    bus.dma_req         = (r_state == S_REQ);
    bus.dma_write_valid = (r_state == S_HDR) || (r_state == S_WDATA);
    bus.dma_write_data  = '0;
    if (r_state == S_HDR)        bus.dma_write_data = r_hdr;
    else if (r_state == S_WDATA) bus.dma_write_data = w_wdata;
    bus.dma_read_ready  = (r_state == S_RDATA);
    bus.core_readData   = bus.dma_read_data;
    bus.core_ready      = '0;
    bus.core_ack        = '0;
    bus.core_done       = '0;
    if (w_active && r_state != S_REQ) bus.core_ready[r_g] = 1'b1;
    if (w_beat)                       bus.core_ack[r_g]   = 1'b1;
    if (r_state == S_END)             bus.core_done[r_g]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr  <= '0;
      r_g   <= '0;
      r_rwn <= 1'b0;
      r_len <= '0;
      r_cnt <= '0;
      r_hdr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
                  r_g   <= w_gidx;
                  r_rwn <= bus.core_rwn[w_gidx];
                  r_len <= bus.core_transferLength[w_gidx*LEN_W +: LEN_W];
                  r_cnt <= '0;
                  r_hdr <= DATA_W'(w_hdr);
                end
        S_END:  begin
                  r_cnt <= '0;
                  r_rr  <= IDX_W'((32'(r_g) + 1) % NUM_CH);
                end
        default: if (w_beat) r_cnt <= r_cnt + 1'b1;
      endcase
    end
  end

`ifdef LSC_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_wdog <= '0;
    else if (!w_active || w_next != r_state || w_beat) r_wdog <= '0;
    else                                            r_wdog <= r_wdog + 1'b1;
  end

  assign err_timeout = w_timeout;
`endif

endmodule

// File: tb/tb_ls_multi_channel_ctrl.sv
// Testbench for ls_multi_channel_ctrl: directed and randomized transfers
// checked against a transaction-level reference (round-robin pick over a
// request mask, arithmetic header construction, per-beat expectations).
module tb_ls_multi_channel_ctrl;
  localparam int NUM_CH  = 3;
  localparam int DATA_W  = 128;
  localparam int HADDR_W = 40;
  localparam int LADDR_W = 14;
  localparam int LEN_W   = 6;
  localparam int LEN_SH  = LADDR_W + 2 + HADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ls_multi_channel_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HADDR_W(HADDR_W),
                             .LADDR_W(LADDR_W), .LEN_W(LEN_W)) bus ();

`ifdef LSC_WATCHDOG_EN
  logic err_timeout;
  ls_multi_channel_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HADDR_W(HADDR_W),
                          .LADDR_W(LADDR_W), .LEN_W(LEN_W), .WDOG_CYC(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_timeout(err_timeout));
`else
  ls_multi_channel_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HADDR_W(HADDR_W),
                          .LADDR_W(LADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int checks   = 0;
  int failures = 0;
  int ptr      = 0;

  logic               ch_rwn   [NUM_CH];
  int                 ch_len   [NUM_CH];
  logic [HADDR_W-1:0] ch_haddr [NUM_CH];
  logic [LADDR_W-1:0] ch_laddr [NUM_CH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int pick(input logic [NUM_CH-1:0] m, input int p);
    for (int k = 0; k < NUM_CH; k++)
      if (m[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_hdr(input logic rwn, input int len,
      input logic [HADDR_W-1:0] ha, input logic [LADDR_W-1:0] la);
    logic [DATA_W-1:0] h;
    h = DATA_W'(la);
    h = h + (DATA_W'(ha) << (LADDR_W + 2));
    h = h + (DATA_W'(len) << LEN_SH);
    h = h + (DATA_W'(rwn ? 8'h01 : 8'h03) << (LEN_SH + LEN_W));
    return h;
  endfunction

  task automatic apply_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      bus.core_rwn[c] = ch_rwn[c];
      bus.core_transferLength[c*LEN_W +: LEN_W] = LEN_W'(ch_len[c]);
      bus.core_hostAddr[c*HADDR_W +: HADDR_W]   = ch_haddr[c];
      bus.core_localAddr[c*LADDR_W +: LADDR_W]  = ch_laddr[c];
    end
  endtask

  task automatic rand_cfg();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_rwn[c]   = 1'($urandom_range(0, 1));
      ch_len[c]   = int'($urandom_range(0, 5));
      ch_haddr[c] = HADDR_W'(rand128());
      ch_laddr[c] = LADDR_W'($urandom());
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dma_req"}, bus.dma_req, 0);
    chk({tag, "_ready"},   bus.core_ready, 0);
    chk({tag, "_ack"},     bus.core_ack, 0);
    chk({tag, "_done"},    bus.core_done, 0);
    chk({tag, "_wvalid"},  bus.dma_write_valid, 0);
    chk({tag, "_wdata"},   bus.dma_write_data, 0);
    chk({tag, "_rready"},  bus.dma_read_ready, 0);
  endtask

  // mode 0: handshakes every cycle; 1: alternating 1/0; 2: random.
  // abort_at >= 0: on that write beat stall 5 cycles, then pulse rst.
  task automatic do_xfer(input logic [NUM_CH-1:0] mask, input int mode, input int abort_at);
    int g, waits, tries, len;
    logic rwn, hs, tog;
    logic [DATA_W-1:0] hdr, wd, rd;
    logic [NUM_CH-1:0] oh;
    apply_cfg();
    g   = pick(mask, ptr);
    rwn = ch_rwn[g];
    len = ch_len[g];
    hdr = exp_hdr(rwn, len, ch_haddr[g], ch_laddr[g]);
    oh  = NUM_CH'(1) << g;
    tog = 1'b1;

    @(posedge clk); #1;
    bus.core_req = mask;
    @(negedge clk);
    chk("idle_dma_req", bus.dma_req, 0);
    chk("idle_ready", bus.core_ready, 0);

    waits = (mode == 0) ? 0 : int'($urandom_range(0, 3));
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      bus.core_req = NUM_CH'($urandom());
      ch_haddr[g]  = HADDR_W'(rand128());
      ch_len[g]    = int'($urandom_range(0, 5));
      apply_cfg();
      bus.dma_resp = (i == waits);
      @(negedge clk);
      chk("req_dma_req", bus.dma_req, 1);
      chk("req_ready", bus.core_ready, 0);
      chk("req_wvalid", bus.dma_write_valid, 0);
    end

    tries = 0;
    do begin
      @(posedge clk); #1;
      bus.core_req = '0;
      bus.dma_resp = 1'b0;
      hs = (mode == 0) || (tries == 3) || ($urandom_range(0, 2) != 0);
      bus.dma_write_ready = hs;
      bus.dma_read_valid  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hdr_valid", bus.dma_write_valid, 1);
      chk("hdr_data", bus.dma_write_data, hdr);
      chk("hdr_ready", bus.core_ready, oh);
      chk("hdr_ack", bus.core_ack, 0);
      chk("hdr_dma_req", bus.dma_req, 0);
      chk("hdr_rready", bus.dma_read_ready, 0);
      tries++;
    end while (!hs);

    for (int b = 0; b < len; b++) begin
      if (!rwn && b == abort_at) begin
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          bus.dma_write_ready = 1'b0;
          wd = rand128();
          bus.core_writeData[g*DATA_W +: DATA_W] = wd;
          @(negedge clk);
          chk("stall_valid", bus.dma_write_valid, 1);
          chk("stall_data", bus.dma_write_data, wd);
          chk("stall_ack", bus.core_ack, 0);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        ptr = 0;
        @(negedge clk);
        chk_zero("post_rst");
        return;
      end
      tries = 0;
      do begin
        @(posedge clk); #1;
        if (mode == 0)      hs = 1'b1;
        else if (mode == 1) begin hs = tog; tog = ~tog; end
        else                hs = (tries == 3) || ($urandom_range(0, 1) == 1);
        for (int c = 0; c < NUM_CH; c++)
          bus.core_writeData[c*DATA_W +: DATA_W] = rand128();
        wd = rand128();
        bus.core_writeData[g*DATA_W +: DATA_W] = wd;
        rd = rand128();
        bus.dma_read_data   = rd;
        bus.dma_write_ready = rwn ? 1'($urandom_range(0, 1)) : hs;
        bus.dma_read_valid  = rwn ? hs : 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!rwn) begin
          chk("wr_valid", bus.dma_write_valid, 1);
          chk("wr_data", bus.dma_write_data, wd);
          chk("wr_rready", bus.dma_read_ready, 0);
        end else begin
          chk("rd_rready", bus.dma_read_ready, 1);
          chk("rd_wvalid", bus.dma_write_valid, 0);
          chk("rd_data", bus.core_readData, rd);
        end
        chk("beat_ack", bus.core_ack, hs ? oh : '0);
        chk("beat_ready", bus.core_ready, oh);
        chk("beat_done", bus.core_done, 0);
        tries++;
      end while (!hs);
    end

    @(posedge clk); #1;
    bus.dma_write_ready = 1'b1;
    bus.dma_read_valid  = 1'b1;
    @(negedge clk);
    chk("end_done", bus.core_done, oh);
    chk("end_ack", bus.core_ack, 0);
    chk("end_wvalid", bus.dma_write_valid, 0);
    chk("end_rready", bus.dma_read_ready, 0);
    chk("end_dma_req", bus.dma_req, 0);
    ptr = (g + 1) % NUM_CH;

    @(posedge clk); #1;
    bus.dma_write_ready = 1'b0;
    bus.dma_read_valid  = 1'b0;
    @(negedge clk);
    chk("after_done", bus.core_done, 0);
    chk("after_ready", bus.core_ready, 0);
    chk("after_ack", bus.core_ack, 0);
    chk("after_rready", bus.dma_read_ready, 0);
  endtask

  initial begin
    logic [NUM_CH-1:0] m;
    bus.core_req = '0;
    bus.core_rwn = '0;
    bus.core_hostAddr = '0;
    bus.core_localAddr = '0;
    bus.core_transferLength = '0;
    bus.core_writeData = '0;
    bus.dma_resp = 1'b0;
    bus.dma_write_ready = 1'b0;
    bus.dma_read_valid = 1'b0;
    bus.dma_read_data = '0;
    rand_cfg();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // ch0 write, len 3, fixed addresses, full rate
    ch_rwn[0] = 1'b0; ch_len[0] = 3; ch_haddr[0] = 40'h12_3456_7800; ch_laddr[0] = 14'h0040;
    do_xfer(3'b001, 0, -1);

    // ch1 read, len 4, valid toggling
    ch_rwn[1] = 1'b1; ch_len[1] = 4;
    do_xfer(3'b010, 1, -1);

    // ch0/ch1 contending: model expects alternating grants
    for (int i = 0; i < 6; i++) begin
      rand_cfg();
      do_xfer(3'b011, 2, -1);
    end

    // zero-length write then read
    ch_rwn[2] = 1'b0; ch_len[2] = 0;
    do_xfer(3'b100, 2, -1);
    ch_rwn[2] = 1'b1; ch_len[2] = 0;
    do_xfer(3'b100, 2, -1);

    // stall then reset mid-write, then a normal transfer
    ch_rwn[0] = 1'b0; ch_len[0] = 5;
    do_xfer(3'b001, 2, 2);
    rand_cfg();
    do_xfer(3'b011, 2, -1);

    // maximum length must not wrap
    ch_rwn[1] = 1'b0; ch_len[1] = (1 << LEN_W) - 1;
    do_xfer(3'b010, 0, -1);
    ch_rwn[2] = 1'b1; ch_len[2] = (1 << LEN_W) - 1;
    do_xfer(3'b100, 0, -1);

    // randomized traffic
    for (int i = 0; i < 20; i++) begin
      rand_cfg();
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      do_xfer(m, 2, -1);
    end

`ifdef LSC_WATCHDOG_EN
    begin
      int g, n;
      logic seen;
      ch_rwn[0] = 1'b0; ch_len[0] = 2;
      apply_cfg();
      g = pick(3'b001, ptr);
      @(posedge clk); #1;
      bus.core_req = 3'b001;
      @(negedge clk);
      chk("wd_idle_err", err_timeout, 0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        @(posedge clk); #1;
        bus.core_req = '0;
        bus.dma_resp = 1'b0;
        @(negedge clk);
        n++;
        if (err_timeout === 1'b1) seen = 1'b1;
        else chk("wd_dma_req", bus.dma_req, 1);
      end
      chk("wd_cycle", 128'(n), 128'(16));
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_done", bus.core_done, NUM_CH'(1) << g);
      chk("wd_err_clear", err_timeout, 0);
      chk("wd_dma_req_off", bus.dma_req, 0);
      ptr = (g + 1) % NUM_CH;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_idle_done", bus.core_done, 0);
      rand_cfg();
      do_xfer(3'b011, 2, -1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
